// File: rtl/vid_mem_arbiter.sv
// vid_mem_arbiter: shares a single-port pixel RAM between display line prefetch and a host port.
//   pixclk, rst_n            : clock, async active-low reset
//   frame_start, line_req    : video timing pulses (rewind frame / fetch next line)
//   fetch_busy, overrun      : prefetch in progress / sticky line_req-while-busy flag
//   lb_bank, lb_wr_*         : ping-pong line buffer write port
//   host_*                   : host valid/ready request port with 1-cycle read return
//   mem_*                    : single-port RAM, 1-cycle read latency
module vid_mem_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 16,
    parameter int H_WORDS = 160,
    parameter int V_LINES = 120
) (
    input  logic              pixclk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              line_req,
    output logic              fetch_busy,
    output logic              lb_bank,
    output logic              lb_wr_en,
    output logic [9:0]        lb_wr_addr,
    output logic [DATA_W-1:0] lb_wr_data,
    output logic              overrun,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int LC_W = $clog2(V_LINES + 1);
    localparam logic [9:0] LAST = 10'(H_WORDS - 1);
    localparam logic [LC_W-1:0] LAST_LINE = LC_W'(V_LINES - 1);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state, state_nxt;
    logic [9:0] k;
    logic [ADDR_W-1:0] base;
    logic [LC_W-1:0] line_cnt;
    logic fs_pend;
    logic accept;
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt  = state;
        fetch_busy = 1'b0;
        host_ready = 1'b0;
        mem_addr   = host_addr;
        mem_wdata  = host_wdata;
        case (state)
            IDLE: begin
                host_ready = !line_req;
                state_nxt  = line_req ? FETCH : IDLE;
            end
            FETCH: begin
                fetch_busy = 1'b1;
                mem_addr   = base + ADDR_W'(k);
                state_nxt  = (k == LAST) ? DRAIN : FETCH;
            end
            DRAIN: begin
                fetch_busy = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        accept = host_valid && host_ready;
        mem_we = accept && host_we;
    end
    // Read data is presented straight from the RAM in the cycle it returns;
    // gating keeps these at zero whenever no write/return is in flight.
    assign lb_wr_data = lb_wr_en ? mem_rdata : '0;
    assign host_rdata = host_rvalid ? mem_rdata : '0;
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            k           <= '0;
            base        <= '0;
            line_cnt    <= '0;
            fs_pend     <= 1'b0;
            lb_bank     <= 1'b0;
            lb_wr_en    <= 1'b0;
            lb_wr_addr  <= '0;
            overrun     <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            k           <= (state == FETCH && k != LAST) ? k + 10'd1 : '0;
            lb_wr_en    <= state == FETCH;
            lb_wr_addr  <= k;
            host_rvalid <= accept && !host_we;
            overrun     <= frame_start ? 1'b0 : (overrun | (line_req & fetch_busy));
            // Base must stay stable while a line is being fetched, so a
            // mid-fetch frame_start is remembered and applied at completion.
            if (state == DRAIN) begin
                lb_bank  <= ~lb_bank;
                fs_pend  <= 1'b0;
                base     <= (fs_pend || frame_start || line_cnt == LAST_LINE) ? '0 : base + ADDR_W'(H_WORDS);
                line_cnt <= (fs_pend || frame_start || line_cnt == LAST_LINE) ? '0 : line_cnt + 1'b1;
            end else if (frame_start) begin
                fs_pend  <= fetch_busy;
                base     <= fetch_busy ? base : '0;
                line_cnt <= fetch_busy ? line_cnt : '0;
            end
        end
    end
endmodule

// File: tb/tb_vid_mem_arbiter.sv
// tb_vid_mem_arbiter: directed self-checking bench for vid_mem_arbiter (H_WORDS=4, V_LINES=3).
module tb_vid_mem_arbiter;
    localparam int AW = 15;
    localparam int DW = 16;
    localparam int HW = 4;
    localparam int VL = 3;
    logic pixclk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic line_req = 1'b0;
    logic fetch_busy, lb_bank, lb_wr_en, overrun, host_ready, host_rvalid, mem_we;
    logic [9:0] lb_wr_addr;
    logic [DW-1:0] lb_wr_data, host_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic host_valid = 1'b0;
    logic host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] ram [0:255];
    int n_chk = 0;
    int n_fail = 0;
    logic exp_bank = 1'b0;

    vid_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .H_WORDS(HW), .V_LINES(VL)) dut (
        .pixclk(pixclk), .rst_n(rst_n), .frame_start(frame_start), .line_req(line_req),
        .fetch_busy(fetch_busy), .lb_bank(lb_bank), .lb_wr_en(lb_wr_en),
        .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data), .overrun(overrun),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 pixclk = ~pixclk;

    always @(posedge pixclk) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
    end

    task automatic next();
        @(posedge pixclk);
        #1;
    endtask

    task automatic test_reset();
        n_chk++;
        if ({fetch_busy, lb_bank, lb_wr_en, overrun, host_rvalid, mem_we} !== 6'b0 ||
            lb_wr_addr !== 10'd0 || lb_wr_data !== 16'd0 || host_rdata !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b bank=%b wr_en=%b ovr=%b rvalid=%b we=%b wa=%0d wd=%h rd=%h exp all 0",
                     fetch_busy, lb_bank, lb_wr_en, overrun, host_rvalid, mem_we, lb_wr_addr, lb_wr_data, host_rdata);
        end
    endtask

    task automatic test_fetch_line(input int base);
        line_req = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge pixclk);
            n_chk++;
            if (fetch_busy !== (c >= 1 && c <= 5)) begin
                n_fail++;
                $display("FAIL fetch_busy base=%0d c=%0d got %b exp %b", base, c, fetch_busy, (c >= 1 && c <= 5));
            end
            if (c >= 1 && c <= 4) begin
                n_chk++;
                if (mem_addr !== AW'(base + c - 1) || mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fetch_addr base=%0d c=%0d got %0d/we=%b exp %0d/we=0", base, c, mem_addr, mem_we, base + c - 1);
                end
            end
            n_chk++;
            if (lb_wr_en !== (c >= 2 && c <= 5)) begin
                n_fail++;
                $display("FAIL lb_wr_en base=%0d c=%0d got %b exp %b", base, c, lb_wr_en, (c >= 2 && c <= 5));
            end
            if (c >= 2 && c <= 5) begin
                n_chk++;
                if (lb_wr_addr !== 10'(c - 2) || lb_wr_data !== DW'(base + c - 2)) begin
                    n_fail++;
                    $display("FAIL lb_write base=%0d c=%0d got (%0d,%0d) exp (%0d,%0d)", base, c, lb_wr_addr, lb_wr_data, c - 2, base + c - 2);
                end
            end
            n_chk++;
            if (lb_bank !== (c == 6 ? ~exp_bank : exp_bank)) begin
                n_fail++;
                $display("FAIL lb_bank base=%0d c=%0d got %b exp %b", base, c, lb_bank, (c == 6 ? ~exp_bank : exp_bank));
            end
            next();
            if (c == 0) line_req = 1'b0;
        end
        exp_bank = ~exp_bank;
    endtask

    task automatic test_fetch();
        test_fetch_line(0);
        test_fetch_line(4);
        test_fetch_line(8);
        test_fetch_line(0);
    endtask

    task automatic test_collision();
        line_req = 1'b1;
        host_valid = 1'b1;
        host_we = 1'b1;
        host_addr = 15'h0010;
        host_wdata = 16'h1234;
        for (int c = 0; c <= 6; c++) begin
            @(negedge pixclk);
            n_chk++;
            if (host_ready !== (c == 6) || mem_we !== (c == 6)) begin
                n_fail++;
                $display("FAIL collision_ready c=%0d got ready=%b we=%b exp %b", c, host_ready, mem_we, (c == 6));
            end
            if (c == 6) begin
                n_chk++;
                if (mem_addr !== 15'h0010 || mem_wdata !== 16'h1234) begin
                    n_fail++;
                    $display("FAIL collision_write got addr=%h data=%h exp 0010/1234", mem_addr, mem_wdata);
                end
            end
            next();
            if (c == 0) line_req = 1'b0;
        end
        exp_bank = ~exp_bank;
        host_we = 1'b0;
        @(negedge pixclk);
        n_chk++;
        if (host_ready !== 1'b1 || mem_we !== 1'b0 || host_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_read_accept got ready=%b we=%b rvalid=%b exp 1/0/0", host_ready, mem_we, host_rvalid);
        end
        next();
        host_valid = 1'b0;
        @(negedge pixclk);
        n_chk++;
        if (host_rvalid !== 1'b1 || host_rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL collision_read_data got rvalid=%b data=%h exp 1/1234", host_rvalid, host_rdata);
        end
        next();
        @(negedge pixclk);
        n_chk++;
        if (host_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_rvalid_drop got %b exp 0", host_rvalid);
        end
        next();
    endtask

    task automatic test_overrun();
        frame_start = 1'b1;
        next();
        frame_start = 1'b0;
        line_req = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge pixclk);
            n_chk++;
            if (overrun !== (c >= 3) || fetch_busy !== (c >= 1 && c <= 5)) begin
                n_fail++;
                $display("FAIL overrun c=%0d got ovr=%b busy=%b exp %b/%b", c, overrun, fetch_busy, (c >= 3), (c >= 1 && c <= 5));
            end
            if (c >= 1 && c <= 4) begin
                n_chk++;
                if (mem_addr !== AW'(c - 1)) begin
                    n_fail++;
                    $display("FAIL overrun_addr c=%0d got %0d exp %0d", c, mem_addr, c - 1);
                end
            end
            next();
            line_req = (c == 1);
        end
        exp_bank = ~exp_bank;
        line_req = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge pixclk);
            n_chk++;
            if (overrun !== (c <= 2)) begin
                n_fail++;
                $display("FAIL overrun_clear c=%0d got %b exp %b", c, overrun, (c <= 2));
            end
            if (c >= 1 && c <= 4) begin
                n_chk++;
                if (mem_addr !== AW'(4 + c - 1)) begin
                    n_fail++;
                    $display("FAIL midframe_addr c=%0d got %0d exp %0d", c, mem_addr, 4 + c - 1);
                end
            end
            next();
            line_req = 1'b0;
            frame_start = (c == 1);
        end
        exp_bank = ~exp_bank;
        test_fetch_line(0);
    endtask

    task automatic test_reset_mid();
        line_req = 1'b1;
        next();
        line_req = 1'b0;
        next();
        n_chk++;
        if (lb_wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre got wr_en=%b exp 1", lb_wr_en);
        end
        rst_n = 1'b0;
        #1;
        test_reset();
        next();
        next();
        rst_n = 1'b1;
        exp_bank = 1'b0;
        @(negedge pixclk);
        n_chk++;
        if (lb_wr_en !== 1'b0 || fetch_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_post got wr_en=%b busy=%b exp 0/0", lb_wr_en, fetch_busy);
        end
        next();
        test_fetch_line(0);
    endtask

    task automatic test_host_stream();
        int accepts = 0;
        int pulses = 0;
        host_we = 1'b0;
        for (int i = 0; i <= 11; i++) begin
            host_valid = (i < 10);
            host_addr = AW'(32 + i);
            @(negedge pixclk);
            if (host_ready && host_valid) accepts++;
            if (host_rvalid) pulses++;
            n_chk++;
            if (host_rvalid !== (i >= 1 && i <= 10)) begin
                n_fail++;
                $display("FAIL stream_rvalid i=%0d got %b exp %b", i, host_rvalid, (i >= 1 && i <= 10));
            end
            if (i >= 1 && i <= 10) begin
                n_chk++;
                if (host_rdata !== DW'(32 + i - 1)) begin
                    n_fail++;
                    $display("FAIL stream_data i=%0d got %h exp %h", i, host_rdata, 32 + i - 1);
                end
            end
            next();
        end
        n_chk++;
        if (accepts != 10 || pulses != 10) begin
            n_fail++;
            $display("FAIL stream_counts got accepts=%0d pulses=%0d exp 10/10", accepts, pulses);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = DW'(i);
        repeat (3) @(posedge pixclk);
        #1;
        test_reset();
        rst_n = 1'b1;
        next();
        test_fetch();
        test_collision();
        test_overrun();
        test_reset_mid();
        test_host_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
